// File: rtl/regbank_wr_arbiter_if.sv
// rtl/regbank_wr_arbiter_if.sv - requester and bank write-port bundle for regbank_wr_arbiter
// master = execution units side, slave = arbiter side.
interface regbank_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*4-1:0]  req_dest;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [3:0]         wr_dest;
    logic [DW-1:0]      wr_data;
    logic [2:0]         wr_src;
    logic               busy_lock;

    modport master (
        output req_valid, req_lock, req_dest, req_data,
        input  req_ready, wr_en, wr_dest, wr_data, wr_src, busy_lock
    );

    modport slave (
        input  req_valid, req_lock, req_dest, req_data,
        output req_ready, wr_en, wr_dest, wr_data, wr_src, busy_lock
    );
endinterface

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - round-robin arbiter with locked bursts for the register bank write port
// Optional macro REGWR_R0_DISCARD_EN: beats to register 0 are accepted but not written.
module regbank_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regbank_wr_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [3:0]      lock_cnt_q, lock_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [3:0]      wr_dest_q, wr_dest_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [2:0]      wr_src_q, wr_src_d;

    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [3:0]      sel_dest;
    logic [DW-1:0]   sel_data;
    logic [3:0]      cnt_inc;

    // Grant selection: owner only while locked, otherwise first valid at or after rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (state_q == ST_LOCKED) begin
            gnt_vld = bus.req_valid[owner_q];
            gnt_idx = owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                cand = PW'((int'(rr_ptr_q) + k) % NREQ);
                if (!gnt_vld && bus.req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign sel_dest = bus.req_dest[int'(gnt_idx) * 4 +: 4];
    assign sel_data = bus.req_data[int'(gnt_idx) * DW +: DW];
    assign cnt_inc  = lock_cnt_q + 4'd1;

    // Held low during reset so no requester believes a beat transferred.
    assign bus.req_ready = (gnt_vld && rst_n) ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (gnt_vld) begin
                    rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                    if (bus.req_lock[gnt_idx] && (LOCK_MAX > 1)) begin
                        state_d    = ST_LOCKED;
                        owner_d    = gnt_idx;
                        lock_cnt_d = 4'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (!gnt_vld) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = 4'd0;
                end else begin
                    lock_cnt_d = cnt_inc;
                    if (!bus.req_lock[owner_q] || (cnt_inc >= 4'(LOCK_MAX))) begin
                        state_d    = ST_ARB;
                        lock_cnt_d = 4'd0;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Write-port payload holds its last value when nothing is accepted.
    always_comb begin
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (gnt_vld) begin
            wr_dest_d = sel_dest;
            wr_data_d = sel_data;
            wr_src_d  = 3'(gnt_idx);
        end
`ifdef REGWR_R0_DISCARD_EN
        wr_en_d = gnt_vld && (sel_dest != 4'd0);
`else
        wr_en_d = gnt_vld;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= 4'd0;
            wr_en_q    <= 1'b0;
            wr_dest_q  <= 4'd0;
            wr_data_q  <= '0;
            wr_src_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_dest_q  <= wr_dest_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_dest   = wr_dest_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.busy_lock = (state_q == ST_LOCKED);
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// tb/tb_regbank_wr_arbiter.sv - directed scoreboard bench for regbank_wr_arbiter
module tb_regbank_wr_arbiter;
    localparam int NREQ     = 4;
    localparam int DW       = 16;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regbank_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    regbank_wr_arbiter #(.NREQ(NREQ), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [3:0]  dest;
        logic [15:0] data;
        logic [2:0]  src;
    } wr_t;

    wr_t sb[$];

    int n_asrt = 0;
    int n_fail = 0;

    logic [3:0]  v, lk;
    logic [3:0]  d  [4];
    logic [15:0] dt [4];

    // Reference model state
    bit          m_locked;
    int          m_ptr, m_owner, m_cnt;
    logic [3:0]  m_dest;
    logic [15:0] m_data;
    logic [2:0]  m_src;

    localparam bit DISCARD =
`ifdef REGWR_R0_DISCARD_EN
        1'b1;
`else
        1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_locked = 1'b0;
        m_ptr = 0; m_owner = 0; m_cnt = 0;
        m_dest = '0; m_data = '0; m_src = '0;
        sb.delete();
    endtask

    task automatic drive();
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.req_dest  = {d[3], d[2], d[1], d[0]};
        bus.req_data  = {dt[3], dt[2], dt[1], dt[0]};
    endtask

    // One clock: drive, check grant, predict the write, clock it in, compare.
    task automatic step();
        int  g;
        wr_t e;
        wr_t o;
        drive();
        #1;
        g = -1;
        if (m_locked) begin
            if (v[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("busy_lock", 32'(bus.busy_lock), 32'(m_locked));
        if (g >= 0) begin
            m_dest = d[g]; m_data = dt[g]; m_src = 3'(g);
        end
        e.en   = (g >= 0) && !(DISCARD && d[g] == 4'd0);
        e.dest = m_dest; e.data = m_data; e.src = m_src;
        sb.push_back(e);
        if (g >= 0) begin
            if (!m_locked) begin
                m_ptr = (g + 1) % NREQ;
                if (lk[g] && LOCK_MAX > 1) begin
                    m_locked = 1'b1; m_owner = g; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (!lk[g] || m_cnt >= LOCK_MAX) m_locked = 1'b0;
            end
        end else begin
            m_locked = 1'b0;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            chk("wr_en",   32'(bus.wr_en),   32'(o.en));
            chk("wr_dest", 32'(bus.wr_dest), 32'(o.dest));
            chk("wr_data", 32'(bus.wr_data), 32'(o.data));
            chk("wr_src",  32'(bus.wr_src),  32'(o.src));
        end
    endtask

    int rr_seq [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int lk_seq [10] = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0};

    initial begin
        reset_model();
        for (int i = 0; i < 4; i++) begin
            d[i] = 4'(i); dt[i] = 16'hA000 + 16'(i);
        end
        v = 4'hF; lk = 4'h0;
        drive();
        #12;
        chk("rst_wr_en",     32'(bus.wr_en),     32'd0);
        chk("rst_wr_dest",   32'(bus.wr_dest),   32'd0);
        chk("rst_wr_data",   32'(bus.wr_data),   32'd0);
        chk("rst_wr_src",    32'(bus.wr_src),    32'd0);
        chk("rst_busy_lock", 32'(bus.busy_lock), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_src",  32'(bus.wr_src),  32'(rr_seq[i]));
            chk("rr_dest", 32'(bus.wr_dest), 32'(rr_seq[i]));
        end

        // Move rr_ptr to 2, then capped locked burst from requester 2
        v = 4'b0010; step();
        v = 4'b0101; lk = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("lock_src", 32'(bus.wr_src), 32'(lk_seq[i]));
        end

        // Early unlock from requester 1 on its third beat
        v = 4'b0010; lk = 4'b0010;
        step(); chk("unl_src0", 32'(bus.wr_src), 32'd1);
        chk("unl_busy", 32'(bus.busy_lock), 32'd1);
        step(); chk("unl_src1", 32'(bus.wr_src), 32'd1);
        lk = 4'b0000;
        step(); chk("unl_src2", 32'(bus.wr_src), 32'd1);
        chk("unl_exit", 32'(bus.busy_lock), 32'd0);
        v = 4'hF;
        step(); chk("unl_ptr2", 32'(bus.wr_src), 32'd2);

        // Idle hold after dest=5 / 0x1234
        v = 4'b1000; d[3] = 4'd5; dt[3] = 16'h1234;
        step(); chk("idle_src", 32'(bus.wr_src), 32'd3);
        v = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_en",   32'(bus.wr_en),   32'd0);
            chk("idle_dest", 32'(bus.wr_dest), 32'd5);
            chk("idle_data", 32'(bus.wr_data), 32'h1234);
        end
        v = 4'hF; d[3] = 4'd3; dt[3] = 16'hA003;
        step(); chk("idle_ptr", 32'(bus.wr_src), 32'd0);

        // Write to register 0 from requester 3
        v = 4'b1000; d[3] = 4'd0;
        drive(); #1;
        chk("r0_ready", 32'(bus.req_ready), 32'b1000);
        step();
        chk("r0_wr_en", 32'(bus.wr_en),   DISCARD ? 32'd0 : 32'd1);
        chk("r0_dest",  32'(bus.wr_dest), 32'd0);
        chk("r0_src",   32'(bus.wr_src),  32'd3);
        d[3] = 4'd3;

        // Reset in the middle of a locked burst
        v = 4'b0001; lk = 4'b0001;
        step(); chk("mid_busy", 32'(bus.busy_lock), 32'd1);
        v = 4'hF; lk = 4'h0; drive();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_wr_en",     32'(bus.wr_en),     32'd0);
        chk("mid_busy_lock", 32'(bus.busy_lock), 32'd0);
        chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        step(); chk("mid_first", 32'(bus.wr_src), 32'd0);
        step(); chk("mid_second", 32'(bus.wr_src), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
